// File: rtl/mmio_pkg.sv
// Shared constants and address decode for the memory-mapped I/O unit.
package mmio_pkg;

    localparam logic [31:0] MMIO_DEFAULT_BASE = 32'h8000_0000;

    // Register offsets from the base address.
    localparam logic [31:0] MMIO_STATUS    = 32'h0000_0000;
    localparam logic [31:0] MMIO_RX_DATA   = 32'h0000_0004;
    localparam logic [31:0] MMIO_TX_DATA   = 32'h0000_0008;
    localparam logic [31:0] MMIO_CLR_FLAGS = 32'h0000_000C;
    localparam logic [31:0] MMIO_CYCLE     = 32'h0000_0010;
    localparam logic [31:0] MMIO_INSTRET   = 32'h0000_0014;
    localparam logic [31:0] MMIO_CNT_RST   = 32'h0000_0018;

    // Status register bit positions.
    localparam int STAT_TX_NOT_FULL  = 0;
    localparam int STAT_RX_NOT_EMPTY = 1;
    localparam int STAT_RX_OVF       = 2;
    localparam int STAT_TX_DROP      = 3;
    localparam int STAT_TX_COUNT_LSB = 8;
    localparam int STAT_RX_COUNT_LSB = 16;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_STATUS,
        SEL_RX_DATA,
        SEL_TX_DATA,
        SEL_CLR_FLAGS,
        SEL_CYCLE,
        SEL_INSTRET,
        SEL_CNT_RST
    } mmio_sel_e;

    // Exact word match of a base-relative offset; anything else is a miss.
    function automatic mmio_sel_e mmio_decode(input logic [31:0] offset);
        mmio_sel_e sel;
        case (offset)
            MMIO_STATUS:    sel = SEL_STATUS;
            MMIO_RX_DATA:   sel = SEL_RX_DATA;
            MMIO_TX_DATA:   sel = SEL_TX_DATA;
            MMIO_CLR_FLAGS: sel = SEL_CLR_FLAGS;
            MMIO_CYCLE:     sel = SEL_CYCLE;
            MMIO_INSTRET:   sel = SEL_INSTRET;
            MMIO_CNT_RST:   sel = SEL_CNT_RST;
            default:        sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mmio_io_unit_sync_fifo.sv
// First-word fall-through synchronous FIFO; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy is tracked by the reset pointers.
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_io_unit.sv
// Memory-mapped I/O unit: register decode, UART TX/RX FIFOs, sticky flags and cycle/instret counters.
module mmio_io_unit
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR         = MMIO_DEFAULT_BASE,
    parameter int          FIFO_DEPTH        = 8,
    parameter int          COUNTER_WIDTH     = 32,
    parameter int          RX_DROP_WHEN_FULL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        instr_retire,
    output logic        rsp_hit,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    localparam int CNT_W = $clog2(FIFO_DEPTH);

    mmio_sel_e                w_sel;
    logic                     w_load;
    logic                     w_store;
    logic                     w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_drop_set;
    logic                     w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_ovf_set;
    logic [7:0]               w_tx_dout, w_rx_dout;
    logic [CNT_W:0]           w_tx_count, w_rx_count;
    logic                     w_clr_flags, w_cnt_rst;
    logic [31:0]              w_status;
    logic                     w_hit;
    logic [31:0]              w_rdata;
    logic                     w_unused;
    logic                     r_rx_ovf, r_tx_drop;
    logic [COUNTER_WIDTH-1:0] r_cycle, r_instret;
    logic                     r_rsp_hit;
    logic [31:0]              r_rsp_rdata;

    assign w_sel       = mmio_decode(req_addr - BASE_ADDR);
    assign w_load      = req_valid & ~req_we;
    assign w_store     = req_valid & req_we;
    assign w_clr_flags = w_store & (w_sel == SEL_CLR_FLAGS);
    assign w_cnt_rst   = w_store & (w_sel == SEL_CNT_RST);
    assign w_unused    = &{1'b0, req_wdata[31:8]};

    // TX: full is judged on the start-of-cycle count, so a pop the same cycle does not rescue a push.
    assign w_tx_push     = w_store & (w_sel == SEL_TX_DATA) & ~w_tx_full;
    assign w_tx_drop_set = w_store & (w_sel == SEL_TX_DATA) & w_tx_full;
    assign w_tx_pop      = ~w_tx_empty & uart_tx_ready;
    assign uart_tx_valid = ~w_tx_empty;
    assign uart_tx_data  = w_tx_dout;

    // RX: either backpressure the uart or accept everything and flag bytes lost while full.
    assign uart_rx_ready = (RX_DROP_WHEN_FULL != 0) ? 1'b1 : ~w_rx_full;
    assign w_rx_push     = uart_rx_valid & uart_rx_ready & ~w_rx_full;
    assign w_rx_ovf_set  = (RX_DROP_WHEN_FULL != 0) & uart_rx_valid & w_rx_full;
    assign w_rx_pop      = w_load & (w_sel == SEL_RX_DATA) & ~w_rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (req_wdata[7:0]),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (uart_rx_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    // Status word assembled from the start-of-cycle state.
    always_comb begin
        w_status                                = '0;
        w_status[STAT_TX_NOT_FULL]              = ~w_tx_full;
        w_status[STAT_RX_NOT_EMPTY]             = ~w_rx_empty;
        w_status[STAT_RX_OVF]                   = r_rx_ovf;
        w_status[STAT_TX_DROP]                  = r_tx_drop;
        w_status[STAT_TX_COUNT_LSB +: 8]        = 8'(w_tx_count);
        w_status[STAT_RX_COUNT_LSB +: 8]        = 8'(w_rx_count);
    end

    // Load data mux; only loads to readable registers hit.
    always_comb begin
        // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
        w_hit   = 1'b0;
        w_rdata = '0;
        if (w_load) begin
            case (w_sel)
                SEL_STATUS: begin
                    w_hit   = 1'b1;
                    w_rdata = w_status;
                end
                SEL_RX_DATA: begin
                    w_hit   = 1'b1;
                    w_rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_dout};
                end
                SEL_CYCLE: begin
                    w_hit   = 1'b1;
                    w_rdata = 32'(r_cycle);
                end
                SEL_INSTRET: begin
                    w_hit   = 1'b1;
                    w_rdata = 32'(r_instret);
                end
                default: ;
            endcase
        end
    end

    // Response register aligns read data with the following stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_hit   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_hit   <= w_hit;
            r_rsp_rdata <= w_rdata;
        end
    end

    assign rsp_hit   = r_rsp_hit;
    assign rsp_rdata = r_rsp_rdata;

    // Sticky flags: a set event wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ovf  <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            r_rx_ovf  <= (r_rx_ovf & ~w_clr_flags) | w_rx_ovf_set;
            r_tx_drop <= (r_tx_drop & ~w_clr_flags) | w_tx_drop_set;
        end
    end

    // Free-running counters; a counter-reset store overrides the increment.
    always_ff @(posedge clk) begin
        if (rst || w_cnt_rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle   <= r_cycle + 1'b1;
            r_instret <= r_instret + COUNTER_WIDTH'(instr_retire);
        end
    end

endmodule

// File: tb/tb_mmio_io_unit.sv
// Bench for mmio_io_unit: two instances (backpressure / drop-when-full) driven with shared stimulus
// and compared every cycle against a queue-based reference model.
module tb_mmio_io_unit;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        instr_retire;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;

    logic        hit_bp, hit_dr;
    logic [31:0] rdata_bp, rdata_dr;
    logic [7:0]  txd_bp, txd_dr;
    logic        txv_bp, txv_dr;
    logic        rxr_bp, rxr_dr;

    int n_cmp = 0;
    int n_err = 0;

    mmio_io_unit #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .COUNTER_WIDTH(32), .RX_DROP_WHEN_FULL(0)) u_dut_bp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .instr_retire(instr_retire), .rsp_hit(hit_bp), .rsp_rdata(rdata_bp),
        .uart_tx_data(txd_bp), .uart_tx_valid(txv_bp), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(rxr_bp)
    );

    mmio_io_unit #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .COUNTER_WIDTH(8), .RX_DROP_WHEN_FULL(1)) u_dut_dr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .instr_retire(instr_retire), .rsp_hit(hit_dr), .rsp_rdata(rdata_dr),
        .uart_tx_data(txd_dr), .uart_tx_valid(txv_dr), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(rxr_dr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  m_tx_q[$];
    logic [7:0]  m_rx_q_bp[$];
    logic [7:0]  m_rx_q_dr[$];
    bit          m_tx_drop;
    bit          m_ovf_dr;
    logic [31:0] m_cycle, m_instret;
    logic [32:0] e_rsp_bp, e_rsp_dr;   // {hit, rdata} expected after the next edge

    function automatic logic [31:0] cmask(input int inst);
        return (inst == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [32:0] model_read(input int inst);
        logic [31:0] off;
        int          txc, rxc;
        bit          ovf;
        logic [7:0]  head;
        off  = req_addr - BASE;
        txc  = m_tx_q.size();
        rxc  = (inst == 0) ? m_rx_q_bp.size() : m_rx_q_dr.size();
        ovf  = (inst == 0) ? 1'b0 : m_ovf_dr;
        head = 8'h00;
        if (rxc > 0) head = (inst == 0) ? m_rx_q_bp[0] : m_rx_q_dr[0];
        if (!req_valid || req_we) return 33'h0;
        case (off)
            32'h00: return {1'b1, 8'h00, 8'(rxc), 8'(txc), 4'h0, m_tx_drop, ovf, rxc > 0, txc < DEPTH};
            32'h04: return {1'b1, 24'h0, head};
            32'h10: return {1'b1, m_cycle & cmask(inst)};
            32'h14: return {1'b1, m_instret & cmask(inst)};
            default: return 33'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] off;
        bit st, ld, tx_full, bp_ready, dr_full, clr, tx_set, ovf_set;
        if (rst) begin
            m_tx_q.delete(); m_rx_q_bp.delete(); m_rx_q_dr.delete();
            m_tx_drop = 0; m_ovf_dr = 0; m_cycle = 0; m_instret = 0;
            e_rsp_bp = '0; e_rsp_dr = '0;
            return;
        end
        e_rsp_bp = model_read(0);
        e_rsp_dr = model_read(1);
        off      = req_addr - BASE;
        st       = req_valid && req_we;
        ld       = req_valid && !req_we;
        tx_full  = (m_tx_q.size() == DEPTH);
        bp_ready = (m_rx_q_bp.size() < DEPTH);
        dr_full  = (m_rx_q_dr.size() == DEPTH);
        tx_set   = 0;
        ovf_set  = 0;
        // TX
        if (m_tx_q.size() > 0 && uart_tx_ready) void'(m_tx_q.pop_front());
        if (st && off == 32'h08) begin
            if (tx_full) tx_set = 1;
            else m_tx_q.push_back(req_wdata[7:0]);
        end
        // RX: cpu pop of the start-of-cycle head, then uart push
        if (ld && off == 32'h04) begin
            if (m_rx_q_bp.size() > 0) void'(m_rx_q_bp.pop_front());
            if (m_rx_q_dr.size() > 0) void'(m_rx_q_dr.pop_front());
        end
        if (uart_rx_valid && bp_ready) m_rx_q_bp.push_back(uart_rx_data);
        if (uart_rx_valid) begin
            if (dr_full) ovf_set = 1;
            else m_rx_q_dr.push_back(uart_rx_data);
        end
        // flags
        clr       = st && off == 32'h0C;
        m_tx_drop = (m_tx_drop && !clr) || tx_set;
        m_ovf_dr  = (m_ovf_dr && !clr) || ovf_set;
        // counters
        if (st && off == 32'h18) begin
            m_cycle = 0; m_instret = 0;
        end else begin
            m_cycle   = m_cycle + 1;
            m_instret = m_instret + 32'(instr_retire);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("hit_bp",   32'(hit_bp), 32'(e_rsp_bp[32]));
        check("rdata_bp", rdata_bp,    e_rsp_bp[31:0]);
        check("hit_dr",   32'(hit_dr), 32'(e_rsp_dr[32]));
        check("rdata_dr", rdata_dr,    e_rsp_dr[31:0]);
        check("txv_bp",   32'(txv_bp), 32'(m_tx_q.size() > 0));
        check("txv_dr",   32'(txv_dr), 32'(m_tx_q.size() > 0));
        if (m_tx_q.size() > 0) begin
            check("txd_bp", 32'(txd_bp), 32'(m_tx_q[0]));
            check("txd_dr", 32'(txd_dr), 32'(m_tx_q[0]));
        end
        check("rxr_bp", 32'(rxr_bp), 32'(m_rx_q_bp.size() < DEPTH));
        check("rxr_dr", 32'(rxr_dr), 32'd1);
    endtask

    // One clock: model consumes the current inputs, outputs are checked at the next falling edge.
    task automatic step();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic access(input bit we, input logic [31:0] off, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_addr = BASE + off; req_wdata = wd;
        step();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, tx_bias, rx_bias;
        rst = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        instr_retire = 0; uart_tx_ready = 0; uart_rx_data = 0; uart_rx_valid = 0;
        step();
        step();
        rst = 1'b0;
        check("rst_rxr_bp", 32'(rxr_bp), 32'd1);
        check("rst_txv_bp", 32'(txv_bp), 32'd0);

        // TX ordering with uart stalled, then drained
        for (int i = 0; i < 3; i++) access(1, 32'h08, 32'h41 + i);
        access(0, 32'h00, 0);
        check("tx_count3", (rdata_bp >> 8) & 32'hFF, 32'd3);
        check("tx_notfull", rdata_bp & 32'h1, 32'd1);
        check("tx_head", 32'(txd_bp), 32'h41);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("tx_order", 32'(txd_bp), 32'h41 + i);
            step();
        end
        check("tx_drained", 32'(txv_bp), 32'd0);
        uart_tx_ready = 1'b0;

        // TX overflow and flag clear
        for (int i = 0; i < 9; i++) access(1, 32'h08, 32'h50 + i);
        access(0, 32'h00, 0);
        check("tx_full_cnt", (rdata_bp >> 8) & 32'hFF, 32'd8);
        check("tx_full_b0", rdata_bp & 32'h1, 32'd0);
        check("tx_drop_b3", (rdata_bp >> 3) & 32'h1, 32'd1);
        access(1, 32'h0C, 32'hDEAD_BEEF);
        access(0, 32'h00, 0);
        check("tx_drop_clr", (rdata_bp >> 3) & 32'h1, 32'd0);
        uart_tx_ready = 1'b1;
        idle(10);
        uart_tx_ready = 1'b0;

        // RX fill beyond depth
        for (int i = 0; i < 10; i++) begin
            uart_rx_valid = 1'b1; uart_rx_data = 8'(i);
            step();
        end
        uart_rx_valid = 1'b0;
        check("rx_bp_ready_full", 32'(rxr_bp), 32'd0);
        access(0, 32'h00, 0);
        check("rx_dr_cnt", (rdata_dr >> 16) & 32'hFF, 32'd8);
        check("rx_dr_ovf", (rdata_dr >> 2) & 32'h1, 32'd1);
        check("rx_bp_cnt", (rdata_bp >> 16) & 32'hFF, 32'd8);
        check("rx_bp_ovf", (rdata_bp >> 2) & 32'h1, 32'd0);
        for (int i = 0; i < 8; i++) begin
            access(0, 32'h04, 0);
            check("rx_pop_dr", rdata_dr, 32'(i));
            check("rx_pop_bp", rdata_bp, 32'(i));
        end
        access(0, 32'h04, 0);
        check("rx_empty_data", rdata_dr, 32'd0);
        check("rx_empty_hit", 32'(hit_dr), 32'd1);
        access(1, 32'h0C, 0);

        // Counters
        access(1, 32'h18, 0);
        for (int i = 0; i < 20; i++) begin
            instr_retire = (i == 1 || i == 4 || i == 7 || i == 12 || i == 19);
            step();
        end
        instr_retire = 1'b0;
        access(0, 32'h14, 0);
        check("instret5_bp", rdata_bp, 32'd5);
        check("instret5_dr", rdata_dr, 32'd5);
        instr_retire = 1'b1;
        access(1, 32'h18, 0);
        instr_retire = 1'b0;
        access(0, 32'h10, 0);
        check("cyc_rst0", rdata_bp, 32'd0);
        instr_retire = 1'b1;
        access(1, 32'h18, 0);
        access(0, 32'h14, 0);
        instr_retire = 1'b0;
        check("instret_rst0", rdata_bp, 32'd0);
        access(1, 32'h18, 0);
        idle(300);
        access(0, 32'h10, 0);
        check("cyc300_bp", rdata_bp, 32'd300);
        check("cyc300_dr_wrap", rdata_dr, 32'd44);

        // Misses
        access(0, 32'h20, 0);
        check("miss_hit", 32'(hit_bp), 32'd0);
        check("miss_data", rdata_bp, 32'd0);
        access(0, 32'h02, 0);
        check("misalign_hit", 32'(hit_bp), 32'd0);
        access(0, 32'h08, 0);
        check("wo_load_hit", 32'(hit_bp), 32'd0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) access(1, 32'h08, 32'h70 + i);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_txv", 32'(txv_bp), 32'd0);
        access(0, 32'h00, 0);
        check("rst_tx_cnt", (rdata_bp >> 8) & 32'hFF, 32'd0);

        // Randomised traffic
        tx_bias = 2; rx_bias = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                tx_bias = $urandom_range(0, 4);
                rx_bias = $urandom_range(0, 3);
            end
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = 1'($urandom_range(0, 1));
            k         = $urandom_range(0, 9);
            case (k)
                0: req_addr = BASE + 32'h00;
                1: req_addr = BASE + 32'h04;
                2: req_addr = BASE + 32'h08;
                3: req_addr = BASE + 32'h0C;
                4: req_addr = BASE + 32'h10;
                5: req_addr = BASE + 32'h14;
                6: req_addr = ($urandom_range(0, 7) == 0) ? BASE + 32'h18 : BASE + 32'h10;
                7: req_addr = BASE + 32'h20;
                8: req_addr = BASE + 32'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
                default: req_addr = $urandom;
            endcase
            req_wdata     = $urandom;
            instr_retire  = 1'($urandom_range(0, 1));
            uart_tx_ready = ($urandom_range(0, 3) < tx_bias);
            uart_rx_valid = ($urandom_range(0, 2) < rx_bias);
            uart_rx_data  = 8'($urandom);
            rst           = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_io_unit.md
Name: mmio_io_unit

Overview:
- Parametrised memory-mapped I/O block for the RISC-V core.
- Replaces the ad hoc UART and counter decode in the core with one unit. Adds TX/RX byte FIFOs, sticky error flags, a selectable RX-full policy and configurable counter width.
- Sits between the core's execute-stage address/data and the external uart handshake.
- Read data returns one cycle after the request, aligned to the memory/writeback stage.

Parameters:
- BASE_ADDR, 32'h8000_0000, word-aligned base of the register map.
- FIFO_DEPTH, 8, entries per TX and RX FIFO; power of 2, range 2..128.
- COUNTER_WIDTH, 32, width of the cycle and instret counters; range 8..32; reads zero-extend.
- RX_DROP_WHEN_FULL, 0: 0 = backpressure the uart (uart_rx_ready = !rx_full); 1 = uart_rx_ready tied 1, bytes arriving while full are dropped and set rx_ovf.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset, sampled on posedge clk
- req_valid  in  1  access request this cycle; core deasserts for stalled or flushed instructions
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- instr_retire  in  1  one instruction retired this cycle
- rsp_hit  out  1  registered: previous-cycle request matched the map
- rsp_rdata  out  32  registered load data for previous-cycle request
- uart_tx_data  out  8  FIFO head to uart data_in
- uart_tx_valid  out  1  = !tx_empty
- uart_tx_ready  in  1  uart data_in_ready
- uart_rx_data  in  8  uart data_out
- uart_rx_valid  in  1  uart data_out_valid
- uart_rx_ready  out  1  uart data_out_ready

Behaviour:
- Register map, offsets from BASE_ADDR, exact word match only:
  - 0x00 R status: [0] tx_not_full, [1] rx_not_empty, [2] rx_ovf sticky, [3] tx_drop sticky, [15:8] tx_count, [23:16] rx_count, other bits 0.
  - 0x04 R RX data {24'0, byte}; pops one entry.
  - 0x08 W TX data; pushes req_wdata[7:0].
  - 0x0C W any value clears rx_ovf and tx_drop.
  - 0x10 R cycle counter.
  - 0x14 R instret counter.
  - 0x18 W any value zeroes both counters.
- Loads to write-only offsets, stores to read-only offsets and unmapped addresses: no side effect. A miss gives rsp_hit = 0 and rsp_rdata = 0 next cycle.
- Latency: a request in cycle N gives rsp_hit/rsp_rdata valid in cycle N+1 only, and 0 in any cycle not following a valid load. Side effects (push, pop, clear, counter reset) commit at the end of cycle N.
- Status and counter reads return the value held during cycle N, i.e. before that edge's updates.
- Counters:
  - cycle increments every cycle.
  - instret increments when instr_retire = 1.
  - Both wrap modulo 2^COUNTER_WIDTH.
  - A reset write in cycle N overrides any increment; both read 0 in cycle N+1.
- TX FIFO:
  - Push on a 0x08 store.
  - Full is evaluated from the start-of-cycle count. A push while full is dropped and sets tx_drop, even if the uart pops the same cycle.
  - Uart pops when uart_tx_valid & uart_tx_ready.
  - Push and pop in the same cycle, not full: count unchanged.
- RX FIFO:
  - Push when uart_rx_valid & uart_rx_ready and not full.
  - RX_DROP_WHEN_FULL = 1 with full and uart_rx_valid: byte lost, rx_ovf set.
  - CPU pop on a 0x04 load. If empty: returns 0, no pop, count unchanged.
  - CPU pop and uart push in the same cycle: both take effect.
- Sticky flags: a set event and a 0x0C clear in the same cycle leaves the flag set (set wins).
- Counts are 8-bit fields; FIFO_DEPTH = 128 full reads 128.
- Reset: FIFOs empty, counts 0, flags 0, counters 0, rsp_hit 0, rsp_rdata 0, uart_tx_valid 0. uart_rx_ready is 1 after reset in both modes.
- Reset mid-operation discards all FIFO contents; a request in the reset cycle is ignored.

Decomposition:
- Shared package mmio_pkg:
  - offset constants MMIO_STATUS, MMIO_RX_DATA, MMIO_TX_DATA, MMIO_CLR_FLAGS, MMIO_CYCLE, MMIO_INSTRET, MMIO_CNT_RST;
  - status bit index constants;
  - default BASE_ADDR.
- One sub-module, sync_fifo (WIDTH, DEPTH):
  - ports push, pop, din, dout (head, first-word fall-through), full, empty, count;
  - ignores push-when-full and pop-when-empty.
  - Instantiated twice.
- Decode, counters and flags stay in mmio_io_unit.

Test Plan:
- Store 0x41, 0x42, 0x43 to 0x80000008 with uart_tx_ready = 0 -> status reads tx_count = 3, bit0 = 1, uart_tx_data = 0x41. Raise ready for 3 cycles -> bytes leave as 41, 42, 43, then uart_tx_valid = 0.
- FIFO_DEPTH = 8, ready = 0, 9 stores -> tx_count = 8, bit0 = 0, bit3 = 1. Store to 0x8000000C -> bit3 = 0.
- RX_DROP_WHEN_FULL = 1, uart delivers 10 bytes 0x00..0x09 -> rx_count = 8, bit2 = 1. Eight loads of 0x80000004 return 0x00..0x07; a ninth returns 0 with rsp_hit = 1.
- RX_DROP_WHEN_FULL = 0, same stimulus -> uart_rx_ready = 0 while full, bit2 = 0, no bytes lost.
- 20 cycles, instr_retire high in 5 of them -> 0x80000014 reads 5. Store to 0x80000018 coinciding with instr_retire = 1 -> next-cycle reads 0 for both counters.
- Load 0x80000020 -> rsp_hit = 0, rsp_rdata = 0. Assert rst with TX holding 3 bytes -> tx_count = 0 and uart_tx_valid = 0 the next cycle.
